// File: rtl/jk_register_bank_pkg.sv
// Shared encodings for the JK register bank: operating modes and per-cell JK input codes.
package jk_register_bank_pkg;

    typedef enum logic [1:0] {
        JKM_JK    = 2'd0,
        JKM_COUNT = 2'd1,
        JKM_SHIFT = 2'd2,
        JKM_LOAD  = 2'd3
    } jk_mode_e;

    // {J,K} codes seen by a single cell.
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_CLEAR  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_register_bank_cell.sv
// Single-bit JK flip-flop with synchronous active-high reset, parameterised reset value and enable.
// q and qbar are both registered so they always change on the same edge.
module jk_cell
    import jk_register_bank_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    logic q_q, q_d;
    logic qbar_q;

    always_comb begin
        q_d = q_q;
        if (en) begin
            case ({j, k})
                JK_HOLD:   q_d = q_q;
                JK_CLEAR:  q_d = 1'b0;
                JK_SET:    q_d = 1'b1;
                JK_TOGGLE: q_d = ~q_q;
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= RST_BIT;
            qbar_q <= ~RST_BIT;
        end else begin
            q_q    <= q_d;
            qbar_q <= ~q_d;
        end
    end

    assign q    = q_q;
    assign qbar = qbar_q;

endmodule

// File: rtl/jk_register_bank.sv
// Bank of WIDTH JK cells operating as JK register, up/down counter, bidirectional shifter or loader.
// Optional macro JKREG_TC_EN adds a terminal-count output tc (next enabled COUNT edge wraps).
module jk_register_bank
    import jk_register_bank_pkg::*;
#(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             dir,
    input  logic             sin,
`ifdef JKREG_TC_EN
    output logic             tc,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    logic [WIDTH-1:0] tgl;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;
    jk_mode_e         mode_e;

    assign mode_e = jk_mode_e'(mode);

    // Counter toggle enables: bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        logic run;
        tgl = '0;
        run = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            tgl[i] = run;
            run    = run & (dir ? ~q[i] : q[i]);
        end
    end

    // Shift and load are expressed as set/clear towards a target word.
    always_comb begin
        tgt = j;
        if (mode_e == JKM_SHIFT)
            tgt = dir ? {sin, q[WIDTH-1:1]} : {q[WIDTH-2:0], sin};
    end

    always_comb begin
        cell_j = j;
        cell_k = k;
        case (mode_e)
            JKM_JK: begin
                cell_j = j;
                cell_k = k;
            end
            JKM_COUNT: begin
                cell_j = tgl;
                cell_k = tgl;
            end
            JKM_SHIFT, JKM_LOAD: begin
                cell_j = tgt;
                cell_k = ~tgt;
            end
            default: begin
                cell_j = j;
                cell_k = k;
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell #(
            .RST_BIT (RST_VAL[i])
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .j    (cell_j[i]),
            .k    (cell_k[i]),
            .q    (q[i]),
            .qbar (qbar[i])
        );
    end

`ifdef JKREG_TC_EN
    assign tc = en & ~rst & (mode_e == JKM_COUNT) & (dir ? (q == '0) : (q == '1));
`endif

endmodule

// File: tb/tb_jk_register_bank.sv
// Scoreboard bench for jk_register_bank: directed plan followed by random stimulus vs a behavioural model.
module tb_jk_register_bank;

    localparam int         W    = 8;
    localparam logic [7:0] RSTV = 8'hA5;

    logic         clk = 1'b0;
    logic         rst, en, dir, sin;
    logic [1:0]   mode;
    logic [W-1:0] j, k, q, qbar;
`ifdef JKREG_TC_EN
    logic         tc;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] m;  // model state

    always #5 clk = ~clk;

    jk_register_bank #(.WIDTH(W), .RST_VAL(RSTV)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .j    (j),
        .k    (k),
        .dir  (dir),
        .sin  (sin),
`ifdef JKREG_TC_EN
        .tc   (tc),
`endif
        .q    (q),
        .qbar (qbar)
    );

    function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic logic [W-1:0] model_next(input logic [W-1:0] cur);
        logic [W-1:0] n;
        n = cur;
        if (rst) n = RSTV;
        else if (!en) n = cur;
        else begin
            case (mode)
                2'd0: for (int i = 0; i < W; i++) begin
                    if (j[i] && k[i]) n[i] = ~cur[i];
                    else if (j[i])    n[i] = 1'b1;
                    else if (k[i])    n[i] = 1'b0;
                end
                2'd1: n = dir ? cur - 8'd1 : cur + 8'd1;
                2'd2: n = dir ? {sin, cur[W-1:1]} : {cur[W-2:0], sin};
                default: n = j;
            endcase
        end
        return n;
    endfunction

    // Drive one cycle of inputs on the falling edge and push the expected post-edge state.
    task automatic step(input logic r, input logic e, input logic [1:0] md,
                        input logic [W-1:0] jj, input logic [W-1:0] kk,
                        input logic d, input logic s);
        logic [W-1:0] nxt;
        @(negedge clk);
        rst = r; en = e; mode = md; j = jj; k = kk; dir = d; sin = s;
        #1;
`ifdef JKREG_TC_EN
        chk("tc", {7'd0, tc},
            {7'd0, (e && !r && md == 2'd1 && (d ? (m == 8'h00) : (m == 8'hFF)))});
`endif
        nxt = model_next(m);
        exp_q.push_back(nxt);
        m = nxt;
    endtask

    // Monitor: every edge for which an expectation exists, compare q and the qbar invariant.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            chk("q", q, e);
            chk("qbar", qbar, ~e);
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'd0; j = '0; k = '0; dir = 1'b0; sin = 1'b0;
        m = RSTV;

        // Reset for two cycles
        step(1, 0, 2'd0, 8'h00, 8'h00, 0, 0);
        step(1, 1, 2'd1, 8'hFF, 8'h00, 0, 1);

        // JK mode from 0F
        step(0, 1, 2'd3, 8'h0F, 8'hFF, 0, 0);
        step(0, 1, 2'd0, 8'hF0, 8'h3C, 0, 0);

        // Count up through wrap, then down through wrap
        step(0, 1, 2'd3, 8'hFE, 8'h00, 0, 0);
        step(0, 1, 2'd1, 8'h00, 8'h00, 0, 0);
        step(0, 1, 2'd1, 8'h00, 8'h00, 0, 0);
        step(0, 1, 2'd1, 8'h00, 8'h00, 0, 0);
        step(0, 1, 2'd3, 8'h00, 8'h00, 0, 0);
        step(0, 1, 2'd1, 8'h00, 8'h00, 1, 0);

        // Shift left then right
        step(0, 1, 2'd3, 8'h81, 8'h00, 0, 0);
        step(0, 1, 2'd2, 8'h00, 8'h00, 0, 0);
        step(0, 1, 2'd2, 8'h00, 8'h00, 1, 1);

        // Held load while disabled, then one enabled edge
        for (int i = 0; i < 4; i++) step(0, 0, 2'd3, 8'h3C, 8'h00, 0, 0);
        step(0, 1, 2'd3, 8'h3C, 8'h00, 0, 0);

        // Reset in the middle of counting
        step(0, 1, 2'd3, 8'h10, 8'h00, 0, 0);
        step(0, 1, 2'd1, 8'h00, 8'h00, 0, 0);
        step(0, 1, 2'd1, 8'h00, 8'h00, 0, 0);
        step(1, 1, 2'd1, 8'h00, 8'h00, 0, 0);
        step(0, 1, 2'd1, 8'h00, 8'h00, 0, 0);

        // Random traffic with occasional reset and disable
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
                 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                 1'($urandom), 1'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
